// File: rtl/const_mem_arbiter.sv
// Arbitrates the single ConstMem read port among NUM_REQ clients: grant, wait MEM_LAT, pulse valid.
// Define CONST_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module const_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [NUM_REQ-1:0]        ivReq,
  input  logic [NUM_REQ*ADDR_W-1:0] ivAddr,
  output logic [NUM_REQ-1:0]        ovGnt,
  output logic [NUM_REQ-1:0]        ovValid,
  output logic [DATA_W-1:0]         ovData,
  output logic [ADDR_W-1:0]         ovMemAddr,
  input  logic [DATA_W-1:0]         ivMemData,
  output logic                      oBusy
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   win_idx;
  logic               win_found;
  logic [ADDR_W-1:0]  win_addr;

`ifdef CONST_ARB_FIXED_PRIO_EN
  always_comb begin
    win_idx   = '0;
    win_found = |ivReq;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (ivReq[i]) win_idx = PTR_W'(i);
    end
  end
`else
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   next_ptr;
  logic [PTR_W-1:0]   offset;
  logic [PTR_W:0]     sum;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0] req_rot;

  // Rotate requests so the pointer sits at bit 0, pick the lowest set bit, then undo the rotation.
  always_comb begin
    req_dbl   = {ivReq, ivReq} >> ptr;
    req_rot   = req_dbl[NUM_REQ-1:0];
    win_found = |ivReq;
    offset    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = PTR_W'(k);
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
    win_idx  = sum[PTR_W-1:0];
    next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
  end
`endif

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == PTR_W'(i)) win_addr = ivAddr[i*ADDR_W +: ADDR_W];
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (win_found) next_state = READ;
      READ:    if (cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant and address are latched in IDLE so later request/address changes cannot disturb a read.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      ovGnt     <= '0;
      ovValid   <= '0;
      ovData    <= '0;
      ovMemAddr <= '0;
      cnt       <= '0;
`ifndef CONST_ARB_FIXED_PRIO_EN
      ptr       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ovValid <= '0;
          if (win_found) begin
            ovGnt     <= NUM_REQ'(1) << win_idx;
            ovMemAddr <= win_addr;
            cnt       <= CNT_W'(MEM_LAT - 1);
`ifndef CONST_ARB_FIXED_PRIO_EN
            ptr       <= next_ptr;
`endif
          end else begin
            ovGnt <= '0;
          end
        end
        READ: begin
          if (cnt == '0) begin
            ovData  <= ivMemData;
            ovValid <= ovGnt;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          ovGnt   <= '0;
          ovValid <= '0;
        end
        default: ;
      endcase
    end
  end

  assign oBusy = (state != IDLE);

endmodule
